// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider for MIPS DIV/DIVU in the EX stage.
// Holds the pipeline via stall_req and emits the HI/LO write bus for one cycle in DONE.
module div_unit #(
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                signed_op,
  input  logic [DATA_W-1:0]   op_a,
  input  logic [DATA_W-1:0]   op_b,
  input  logic                annul,
  output logic                stall_req,
  output logic                result_valid,
  output logic [2*DATA_W+1:0] hilo_bus,
  output logic [1:0]          dbg_state
);

  localparam int CNT_W = $clog2(DATA_W);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_DIV  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] rem_q, rem_d;
  logic [DATA_W-1:0] quo_q, quo_d;
  logic [DATA_W-1:0] dvs_q, dvs_d;
  logic              neg_quo_q, neg_quo_d;
  logic              neg_rem_q, neg_rem_d;

  logic [DATA_W-1:0] abs_a, abs_b;
  logic [DATA_W:0]   rem_sh, trial;
  logic [DATA_W-1:0] rem_nx, quo_nx;
  logic              issue;

  // Handshake: start is a level request honoured only in IDLE; the issuing
  // instruction is held by stall_req until DONE, where it advances with its result.
  assign issue = (state_q == S_IDLE) && start && !annul;

  assign abs_a = (signed_op && op_a[DATA_W-1]) ? -op_a : op_a;
  assign abs_b = (signed_op && op_b[DATA_W-1]) ? -op_b : op_b;

  // rem stays below the divisor, so the shifted value and the trial fit in DATA_W+1 bits.
  assign rem_sh = {rem_q, quo_q[DATA_W-1]};
  assign trial  = rem_sh - {1'b0, dvs_q};
  assign rem_nx = trial[DATA_W] ? rem_sh[DATA_W-1:0] : trial[DATA_W-1:0];
  assign quo_nx = {quo_q[DATA_W-2:0], ~trial[DATA_W]};

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    case (state_q)
      S_IDLE: begin
        if (issue) begin
          cnt_d = '0;
          if (op_b != '0) begin
            rem_d     = '0;
            quo_d     = abs_a;
            dvs_d     = abs_b;
            neg_quo_d = signed_op && (op_a[DATA_W-1] ^ op_b[DATA_W-1]);
            neg_rem_d = signed_op && op_a[DATA_W-1];
            state_d   = S_DIV;
          end else begin
            rem_d     = op_a;
            quo_d     = '1;
            neg_quo_d = 1'b0;
            neg_rem_d = 1'b0;
            state_d   = S_DONE;
          end
        end
      end
      S_DIV: begin
        if (annul) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          rem_d = rem_nx;
          quo_d = quo_nx;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(DATA_W - 1)) begin
            // Final bit: fold in the sign so DONE only has to present the registers.
            quo_d   = neg_quo_q ? -quo_nx : quo_nx;
            rem_d   = neg_rem_q ? -rem_nx : rem_nx;
            cnt_d   = '0;
            state_d = S_DONE;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvs_q     <= dvs_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
    end
  end

  // Gated by rst so a start held during reset cannot raise a stall.
  assign stall_req    = rst && (issue || (state_q == S_DIV));
  assign result_valid = (state_q == S_DONE);
  assign hilo_bus     = (state_q == S_DONE) ? {~annul, ~annul, rem_q, quo_q} : '0;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: issue, latency, sign handling, divide by zero,
// annul in DIV/DONE/IDLE, asynchronous reset mid-operation and operand toggling.
module tb_div_unit;

  localparam int W = 32;

  logic           clk;
  logic           rst;
  logic           start;
  logic           signed_op;
  logic [W-1:0]   op_a;
  logic [W-1:0]   op_b;
  logic           annul;
  logic           stall_req;
  logic           result_valid;
  logic [2*W+1:0] hilo_bus;
  logic [1:0]     dbg_state;

  int n_checks = 0;
  int n_fails  = 0;

  div_unit #(.DATA_W(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .signed_op    (signed_op),
    .op_a         (op_a),
    .op_b         (op_b),
    .annul        (annul),
    .stall_req    (stall_req),
    .result_valid (result_valid),
    .hilo_bus     (hilo_bus),
    .dbg_state    (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [2*W+1:0] got, input logic [2*W+1:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fails++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full operation from issue cycle to the idle cycle after DONE.
  task automatic do_div(input string tag, input logic s, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] exp_hi,
                        input logic [W-1:0] exp_lo, input logic annul_done,
                        input logic toggle);
    int lat;
    logic we;
    lat = (b == '0) ? 1 : W + 1;
    we  = !annul_done;
    signed_op = s;
    op_a      = a;
    op_b      = b;
    start     = 1'b1;
    #1;
    check({tag, " issue stall"}, 66'(stall_req), 66'(1));
    check({tag, " issue valid"}, 66'(result_valid), 66'(0));
    tick();
    start = 1'b0;
    for (int c = 1; c <= lat; c++) begin
      if (toggle && c < lat) begin
        op_a      = $urandom;
        op_b      = $urandom;
        signed_op = 1'($urandom_range(0, 1));
        start     = 1'($urandom_range(0, 1));
      end
      if (c == lat) begin
        start = 1'b0;
        annul = annul_done;
      end
      #1;
      if (c < lat) begin
        check({tag, " busy stall"}, 66'(stall_req), 66'(1));
        check({tag, " busy valid"}, 66'(result_valid), 66'(0));
      end else begin
        check({tag, " done valid"}, 66'(result_valid), 66'(1));
        check({tag, " done stall"}, 66'(stall_req), 66'(0));
        check({tag, " done bus"}, hilo_bus, {we, we, exp_hi, exp_lo});
      end
      tick();
    end
    annul = 1'b0;
    #1;
    check({tag, " after valid"}, 66'(result_valid), 66'(0));
    check({tag, " after stall"}, 66'(stall_req), 66'(0));
    check({tag, " after bus"}, hilo_bus, 66'(0));
  endtask

  initial begin
    logic seen_valid;
    rst       = 1'b0;
    start     = 1'b0;
    signed_op = 1'b0;
    op_a      = '0;
    op_b      = '0;
    annul     = 1'b0;

    // Reset held with start asserted: everything must stay quiet.
    #12;
    start = 1'b1;
    op_a  = 32'd100;
    op_b  = 32'd7;
    #1;
    check("reset stall", 66'(stall_req), 66'(0));
    check("reset valid", 66'(result_valid), 66'(0));
    check("reset bus", hilo_bus, 66'(0));
    check("reset state", 66'(dbg_state), 66'(0));
    start = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    check("release stall", 66'(stall_req), 66'(0));
    check("release bus", hilo_bus, 66'(0));
    tick();

    do_div("divu 100/7", 1'b0, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 1'b0);
    do_div("div -7/2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 1'b0);
    do_div("div 7/-2", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 1'b0, 1'b0);
    do_div("div min/-1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0, 1'b0);
    do_div("divu min/max", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0, 1'b0);
    do_div("divu by 0", 1'b0, 32'h1234, 32'd0, 32'h1234, 32'hFFFF_FFFF, 1'b0, 1'b0);
    do_div("div -8/0", 1'b1, 32'hFFFF_FFF8, 32'd0, 32'hFFFF_FFF8, 32'hFFFF_FFFF, 1'b0, 1'b0);
    do_div("div -100/7", 1'b1, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFF2, 1'b0, 1'b0);
    do_div("divu max/1", 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'hFFFF_FFFF, 1'b0, 1'b0);
    do_div("divu deadbeef/16", 1'b0, 32'hDEAD_BEEF, 32'h10, 32'hF, 32'h0DEA_DBEE, 1'b0, 1'b0);
    do_div("div -9/-4", 1'b1, 32'hFFFF_FFF7, 32'hFFFF_FFFC, 32'hFFFF_FFFF, 32'd2, 1'b0, 1'b0);
    do_div("divu 3/5", 1'b0, 32'd3, 32'd5, 32'd3, 32'd0, 1'b0, 1'b0);

    // Operands and start churn while dividing; the captured values must win.
    do_div("toggle 1000/3", 1'b0, 32'd1000, 32'd3, 32'd1, 32'd333, 1'b0, 1'b1);

    // Annul landing on the DONE cycle suppresses the write enables.
    do_div("annul done", 1'b0, 32'd100, 32'd7, 32'd2, 32'd14, 1'b1, 1'b0);

    // Annul together with start in IDLE: nothing starts.
    op_a  = 32'd55;
    op_b  = 32'd5;
    start = 1'b1;
    annul = 1'b1;
    #1;
    check("annul idle stall", 66'(stall_req), 66'(0));
    tick();
    start = 1'b0;
    annul = 1'b0;
    #1;
    check("annul idle state", 66'(dbg_state), 66'(0));
    check("annul idle valid", 66'(result_valid), 66'(0));
    tick();

    // Annul at cycle 10 of a DIV, then a fresh start at cycle 12.
    signed_op = 1'b0;
    op_a      = 32'd999;
    op_b      = 32'd4;
    start     = 1'b1;
    #1;
    check("annul div issue stall", 66'(stall_req), 66'(1));
    tick();
    start = 1'b0;
    seen_valid = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      #1;
      seen_valid = seen_valid | result_valid;
      tick();
    end
    annul = 1'b1;
    #1;
    check("annul div c10 stall", 66'(stall_req), 66'(1));
    seen_valid = seen_valid | result_valid;
    tick();
    annul = 1'b0;
    #1;
    check("annul div c11 stall", 66'(stall_req), 66'(0));
    check("annul div c11 state", 66'(dbg_state), 66'(0));
    seen_valid = seen_valid | result_valid;
    check("annul div no pulse", 66'(seen_valid), 66'(0));
    tick();
    do_div("after annul 1000/3", 1'b0, 32'd1000, 32'd3, 32'd1, 32'd333, 1'b0, 1'b0);

    // Asynchronous reset in cycle 5 of a DIV.
    signed_op = 1'b0;
    op_a      = 32'd50000;
    op_b      = 32'd9;
    start     = 1'b1;
    #1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 4; c++) tick();
    #1;
    check("pre reset stall", 66'(stall_req), 66'(1));
    rst = 1'b0;
    #1;
    check("async reset stall", 66'(stall_req), 66'(0));
    check("async reset valid", 66'(result_valid), 66'(0));
    check("async reset bus", hilo_bus, 66'(0));
    check("async reset state", 66'(dbg_state), 66'(0));
    tick();
    rst = 1'b1;
    seen_valid = 1'b0;
    for (int c = 0; c < W + 4; c++) begin
      #1;
      seen_valid = seen_valid | result_valid | stall_req;
      tick();
    end
    check("reset discards result", 66'(seen_valid), 66'(0));
    do_div("after reset 50000/9", 1'b0, 32'd50000, 32'd9, 32'd5, 32'd5555, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
